// File: rtl/gcd_ctrl_if.sv
// ============================================================================
// Module      : gcd_ctrl_if
// Description : Handshake, comparator-flag and datapath-control bundle
//               between the GCD controller and its requester/datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gcd_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             ldA;
  logic             ldB;
  logic             sel_in;
  logic             sel1;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  // Requester plus datapath side: issues start, supplies comparator flags.
  modport master (
    output start, lt, gt, eq,
    input  ldA, ldB, sel_in, sel1, busy, done, err, iter_count
  );

  // Controller side.
  modport slave (
    input  start, lt, gt, eq,
    output ldA, ldB, sel_in, sel1, busy, done, err, iter_count
  );
endinterface

`default_nettype wire

// File: rtl/gcd_ctrl.sv
// ============================================================================
// Module      : gcd_ctrl
// Description : Control FSM for a subtractive-GCD datapath with two PIPO
//               operand registers, iteration limit and start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_ctrl #(
  parameter int MAX_ITER = 1023,
  parameter int CNT_W    = 10
) (
  input  wire logic   clk,
  input  wire logic   rst,
  gcd_ctrl_if.slave   ctrl
);

  localparam logic [CNT_W-1:0] c_max_iter = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPARE = 3'd3,
    S_SUB_A   = 3'd4,
    S_SUB_B   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;

  logic w_ldA;
  logic w_ldB;
  logic w_sel_in;
  logic w_sel1;
  logic w_busy;
  logic w_done;
  logic w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Limit is checked in COMPARE before any further subtract, so the counter
  // can never pass MAX_ITER and therefore never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter <= '0;
    end else if (r_state == S_IDLE && ctrl.start) begin
      r_iter <= '0;
    end else if (r_state == S_SUB_A || r_state == S_SUB_B) begin
      r_iter <= r_iter + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (ctrl.start) w_next = S_LOAD_A;
      S_LOAD_A:  w_next = S_LOAD_B;
      S_LOAD_B:  w_next = S_COMPARE;
      S_COMPARE: begin
        if (ctrl.eq) begin
          w_next = S_DONE;
        end else if (r_iter == c_max_iter) begin
          w_next = S_ERR;
        end else if (ctrl.gt) begin
          w_next = S_SUB_A;
        end else if (ctrl.lt) begin
          w_next = S_SUB_B;
        end else begin
          w_next = S_ERR;
        end
      end
      S_SUB_A:   w_next = S_COMPARE;
      S_SUB_B:   w_next = S_COMPARE;
      S_DONE:    w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    w_ldA    = 1'b0;
    w_ldB    = 1'b0;
    w_sel_in = 1'b0;
    w_sel1   = 1'b0;
    w_busy   = (r_state != S_IDLE);
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_ldA    = 1'b1;
        w_sel_in = 1'b1;
      end
      S_LOAD_B: begin
        w_ldB    = 1'b1;
        w_sel_in = 1'b1;
      end
      S_SUB_A: begin
        w_ldA = 1'b1;
      end
      S_SUB_B: begin
        w_ldB  = 1'b1;
        w_sel1 = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      S_ERR: begin
        w_done = 1'b1;
        w_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.ldA        = w_ldA;
  assign ctrl.ldB        = w_ldB;
  assign ctrl.sel_in     = w_sel_in;
  assign ctrl.sel1       = w_sel1;
  assign ctrl.busy       = w_busy;
  assign ctrl.done       = w_done;
  assign ctrl.err        = w_err;
  assign ctrl.iter_count = r_iter;

endmodule

`default_nettype wire
